mesi_core_bus_agent: RTL and testbench

- Per-core bus agent between one core's cache controller and mesi_isc, one instance per core (0..3).
- Upstream of mesi_isc: turns core write/read requests into mbus broadcast commands and holds each until mbus ack.
- Downstream of mesi_isc: consumes this core's cbus commands, acks snoops after a programmable lookup latency, notifies the cache of snoops, and completes the core's own request on the enable command.

---
 rtl/mesi_core_bus_agent.sv | 194 +++++++++++++++++++
 tb/tb_mesi_core_bus_agent.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_core_bus_agent.sv
// Per-core MESI bus agent: issues this core's broadcast requests on mbus and
// answers this core's cbus snoop/enable commands with a single ack each.
module mesi_core_bus_agent #(
  parameter int ADDR_WIDTH = 32,
  parameter int SNOOP_LAT  = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wr_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  done_o,
  output logic                  done_wr_o,
  output logic [2:0]            mbus_cmd_o,
  output logic [ADDR_WIDTH-1:0] mbus_addr_o,
  input  logic                  mbus_ack_i,
  input  logic [2:0]            cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0] cbus_addr_i,
  output logic                  cbus_ack_o,
  output logic                  snoop_valid_o,
  output logic                  snoop_wr_o,
  output logic [ADDR_WIDTH-1:0] snoop_addr_o,
  output logic                  err_o
);

  localparam logic [1:0] REQ_IDLE = 2'd0;
  localparam logic [1:0] REQ_REQ  = 2'd1;
  localparam logic [1:0] REQ_WAIT = 2'd2;

  localparam logic [1:0] SN_IDLE  = 2'd0;
  localparam logic [1:0] SN_LAT   = 2'd1;
  localparam logic [1:0] SN_ACK   = 2'd2;
  localparam logic [1:0] SN_REARM = 2'd3;

  localparam logic [2:0] MBUS_NOP = 3'd0;
  localparam logic [2:0] MBUS_WR  = 3'd3;
  localparam logic [2:0] MBUS_RD  = 3'd4;

  localparam logic [2:0] CBUS_NOP      = 3'd0;
  localparam logic [2:0] CBUS_WR_SNOOP = 3'd1;
  localparam logic [2:0] CBUS_RD_SNOOP = 3'd2;
  localparam logic [2:0] CBUS_EN_WR    = 3'd3;
  localparam logic [2:0] CBUS_EN_RD    = 3'd4;

  localparam logic [3:0]  LAT_C     = 4'(SNOOP_LAT);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [1:0]            req_st_q, req_st_d;
  logic                  ready_q, ready_d;
  logic                  pend_wr_q, pend_wr_d;
  logic [ADDR_WIDTH-1:0] mbus_addr_q, mbus_addr_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  done_q, done_d;
  logic                  done_wr_q, done_wr_d;
  logic [1:0]            sn_st_q, sn_st_d;
  logic [3:0]            lat_cnt_q, lat_cnt_d;
  logic                  ack_q, ack_d;
  logic                  snoop_valid_q, snoop_valid_d;
  logic                  snoop_wr_q, snoop_wr_d;
  logic [ADDR_WIDTH-1:0] snoop_addr_q, snoop_addr_d;
  logic                  err_q, err_d;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case
    // statements leaves a signal unassigned and infers a latch.
    req_st_d      = req_st_q;
    pend_wr_d     = pend_wr_q;
    mbus_addr_d   = mbus_addr_q;
    tmo_cnt_d     = tmo_cnt_q;
    done_d        = 1'b0;
    done_wr_d     = done_wr_q;
    sn_st_d       = sn_st_q;
    lat_cnt_d     = lat_cnt_q;
    ack_d         = 1'b0;
    snoop_valid_d = 1'b0;
    snoop_wr_d    = snoop_wr_q;
    snoop_addr_d  = snoop_addr_q;
    err_d         = err_q;

    case (req_st_q)
      REQ_IDLE: begin
        if (req_valid_i && ready_q) begin
          req_st_d    = REQ_REQ;
          pend_wr_d   = req_wr_i;
          mbus_addr_d = req_addr_i;
          tmo_cnt_d   = 16'd0;
        end
      end
      REQ_REQ: begin
        if (tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
        // Timeout only flags the error; the broadcast stays on mbus.
        if (tmo_cnt_d >= TIMEOUT_C) err_d = 1'b1;
        if (mbus_ack_i) req_st_d = REQ_WAIT;
      end
      default: ;
    endcase

    case (sn_st_q)
      SN_IDLE: begin
        case (cbus_cmd_i)
          CBUS_NOP: ;
          CBUS_WR_SNOOP, CBUS_RD_SNOOP: begin
            snoop_valid_d = 1'b1;
            snoop_wr_d    = (cbus_cmd_i == CBUS_WR_SNOOP);
            snoop_addr_d  = cbus_addr_i;
            if (LAT_C == 4'd0) begin
              ack_d   = 1'b1;
              sn_st_d = SN_ACK;
            end else begin
              lat_cnt_d = LAT_C;
              sn_st_d   = SN_LAT;
            end
          end
          CBUS_EN_WR, CBUS_EN_RD: begin
            ack_d   = 1'b1;
            sn_st_d = SN_ACK;
            if (req_st_q == REQ_WAIT) begin
              done_d    = 1'b1;
              done_wr_d = pend_wr_q;
              req_st_d  = REQ_IDLE;
              if ((cbus_cmd_i == CBUS_EN_WR) != pend_wr_q) err_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      SN_LAT: begin
        if (lat_cnt_q <= 4'd1) begin
          ack_d   = 1'b1;
          sn_st_d = SN_ACK;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      // The acked command stays on cbus until mesi_isc sees the ack; wait for NOP.
      SN_ACK:   sn_st_d = (cbus_cmd_i == CBUS_NOP) ? SN_IDLE : SN_REARM;
      default:  if (cbus_cmd_i == CBUS_NOP) sn_st_d = SN_IDLE;
    endcase

    // Ready is a flop so it stays low in reset and during the completion cycle.
    ready_d = (req_st_q == REQ_IDLE) && (req_st_d == REQ_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_st_q      <= REQ_IDLE;
      ready_q       <= 1'b0;
      pend_wr_q     <= 1'b0;
      mbus_addr_q   <= '0;
      tmo_cnt_q     <= 16'd0;
      done_q        <= 1'b0;
      done_wr_q     <= 1'b0;
      sn_st_q       <= SN_IDLE;
      lat_cnt_q     <= 4'd0;
      ack_q         <= 1'b0;
      snoop_valid_q <= 1'b0;
      snoop_wr_q    <= 1'b0;
      snoop_addr_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      req_st_q      <= req_st_d;
      ready_q       <= ready_d;
      pend_wr_q     <= pend_wr_d;
      mbus_addr_q   <= mbus_addr_d;
      tmo_cnt_q     <= tmo_cnt_d;
      done_q        <= done_d;
      done_wr_q     <= done_wr_d;
      sn_st_q       <= sn_st_d;
      lat_cnt_q     <= lat_cnt_d;
      ack_q         <= ack_d;
      snoop_valid_q <= snoop_valid_d;
      snoop_wr_q    <= snoop_wr_d;
      snoop_addr_q  <= snoop_addr_d;
      err_q         <= err_d;
    end
  end

  assign req_ready_o   = ready_q;
  assign mbus_cmd_o    = (req_st_q != REQ_REQ) ? MBUS_NOP : (pend_wr_q ? MBUS_WR : MBUS_RD);
  assign mbus_addr_o   = mbus_addr_q;
  assign done_o        = done_q;
  assign done_wr_o     = done_wr_q;
  assign cbus_ack_o    = ack_q;
  assign snoop_valid_o = snoop_valid_q;
  assign snoop_wr_o    = snoop_wr_q;
  assign snoop_addr_o  = snoop_addr_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_mesi_core_bus_agent.sv
// Directed bench for mesi_core_bus_agent: per-cycle vector table plus
// hand-written reset, timeout, stray-enable and reserved-code sequences.
module tb_mesi_core_bus_agent;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_wr_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic        done_o, done_wr_o;
  logic [2:0]  mbus_cmd_o;
  logic [31:0] mbus_addr_o;
  logic        mbus_ack_i = 1'b0;
  logic [2:0]  cbus_cmd_i = 3'd0;
  logic [31:0] cbus_addr_i = '0;
  logic        cbus_ack_o, snoop_valid_o, snoop_wr_o;
  logic [31:0] snoop_addr_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mesi_core_bus_agent #(.ADDR_WIDTH(32), .SNOOP_LAT(2), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i), .done_o(done_o), .done_wr_o(done_wr_o),
    .mbus_cmd_o(mbus_cmd_o), .mbus_addr_o(mbus_addr_o), .mbus_ack_i(mbus_ack_i),
    .cbus_cmd_i(cbus_cmd_i), .cbus_addr_i(cbus_addr_i), .cbus_ack_o(cbus_ack_o),
    .snoop_valid_o(snoop_valid_o), .snoop_wr_o(snoop_wr_o),
    .snoop_addr_o(snoop_addr_o), .err_o(err_o)
  );

  typedef struct {
    logic        v;
    logic        wr;
    logic [31:0] addr;
    logic        mack;
    logic [2:0]  ccmd;
    logic [31:0] caddr;
    logic        rdy;
    logic        done;
    logic        dwr;
    logic [2:0]  mcmd;
    logic [31:0] maddr;
    logic        ack;
    logic        snv;
    logic        swr;
    logic [31:0] saddr;
    logic        err;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, wr, input logic [31:0] addr, input logic mack,
                     input logic [2:0] ccmd, input logic [31:0] caddr,
                     input logic rdy, done, dwr, input logic [2:0] mcmd,
                     input logic [31:0] maddr, input logic ack, snv, swr,
                     input logic [31:0] saddr, input logic err);
    vecs[nv] = '{v, wr, addr, mack, ccmd, caddr, rdy, done, dwr, mcmd, maddr,
                 ack, snv, swr, saddr, err};
    nv++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_i = 1'b0;
    req_wr_i    = 1'b0;
    req_addr_i  = '0;
    mbus_ack_i  = 1'b0;
    cbus_cmd_i  = 3'd0;
    cbus_addr_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rdy"},   32'(req_ready_o),   32'd0);
    check({tag, " done"},  32'(done_o),        32'd0);
    check({tag, " dwr"},   32'(done_wr_o),     32'd0);
    check({tag, " mcmd"},  32'(mbus_cmd_o),    32'd0);
    check({tag, " maddr"}, mbus_addr_o,        32'd0);
    check({tag, " ack"},   32'(cbus_ack_o),    32'd0);
    check({tag, " snv"},   32'(snoop_valid_o), 32'd0);
    check({tag, " swr"},   32'(snoop_wr_o),    32'd0);
    check({tag, " saddr"}, snoop_addr_o,       32'd0);
    check({tag, " err"},   32'(err_o),         32'd0);
  endtask

  initial begin
    // Each row: inputs for one cycle, then outputs expected after that edge.
    //   v  wr addr         mk cc caddr          rdy dn dw mc maddr         ak sv sw saddr         er
    add(0, 0, 32'h0,        0, 0, 32'h0,         1,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(1, 0, 32'h1000,     0, 0, 32'h0,         0,  0, 0, 4, 32'h1000,     0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h1000,     0, 0, 32'h0,         0,  0, 0, 4, 32'h1000,     0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        1, 0, 32'h0,         0,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 0, 32'h0,         0,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 4, 32'h0,         0,  1, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 1, 32'hDEADBEE0,  1,  0, 0, 0, 32'h0,        0, 1, 1, 32'hDEADBEE0, 0);
    add(0, 0, 32'h0,        0, 1, 32'hDEADBEE0,  1,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 1, 32'hDEADBEE0,  1,  0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 1, 32'hDEADBEE0,  1,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 1, 32'hDEADBEE0,  1,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(1, 1, 32'h2000,     0, 0, 32'h0,         0,  0, 0, 3, 32'h2000,     0, 0, 0, 32'h0,        0);
    add(0, 1, 32'h2000,     1, 0, 32'h0,         0,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 2, 32'h2040,      0,  0, 0, 0, 32'h0,        0, 1, 0, 32'h2040,     0);
    add(0, 0, 32'h0,        0, 2, 32'h2040,      0,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 2, 32'h2040,      0,  0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 0, 32'h0,         0,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 3, 32'h0,         0,  1, 1, 0, 32'h0,        1, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(1, 1, 32'h3000,     0, 0, 32'h0,         0,  0, 0, 3, 32'h3000,     0, 0, 0, 32'h0,        0);
    add(0, 1, 32'h3000,     1, 0, 32'h0,         0,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 4, 32'h0,         0,  1, 1, 0, 32'h0,        1, 0, 0, 32'h0,        1);
    add(0, 0, 32'h0,        0, 0, 32'h0,         1,  0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1);

    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < nv; i++) begin
      req_valid_i = vecs[i].v;
      req_wr_i    = vecs[i].wr;
      req_addr_i  = vecs[i].addr;
      mbus_ack_i  = vecs[i].mack;
      cbus_cmd_i  = vecs[i].ccmd;
      cbus_addr_i = vecs[i].caddr;
      step();
      check($sformatf("v%0d rdy", i),  32'(req_ready_o),   32'(vecs[i].rdy));
      check($sformatf("v%0d done", i), 32'(done_o),        32'(vecs[i].done));
      check($sformatf("v%0d mcmd", i), 32'(mbus_cmd_o),    32'(vecs[i].mcmd));
      check($sformatf("v%0d ack", i),  32'(cbus_ack_o),    32'(vecs[i].ack));
      check($sformatf("v%0d snv", i),  32'(snoop_valid_o), 32'(vecs[i].snv));
      check($sformatf("v%0d err", i),  32'(err_o),         32'(vecs[i].err));
      if (vecs[i].done)
        check($sformatf("v%0d dwr", i), 32'(done_wr_o), 32'(vecs[i].dwr));
      if (vecs[i].mcmd != 3'd0)
        check($sformatf("v%0d maddr", i), mbus_addr_o, vecs[i].maddr);
      if (vecs[i].snv) begin
        check($sformatf("v%0d swr", i),   32'(snoop_wr_o), 32'(vecs[i].swr));
        check($sformatf("v%0d saddr", i), snoop_addr_o,    vecs[i].saddr);
      end
    end

    // Reset while a read is in REQ and a snoop latency countdown is running.
    idle_inputs();
    req_valid_i = 1'b1;
    req_addr_i  = 32'h4000;
    step();
    req_valid_i = 1'b0;
    cbus_cmd_i  = 3'd1;
    cbus_addr_i = 32'h4440;
    step();
    check("midrst snv before", 32'(snoop_valid_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    cbus_cmd_i = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step();
    check("post rst rdy",  32'(req_ready_o), 32'd1);
    check("post rst mcmd", 32'(mbus_cmd_o),  32'd0);
    check("post rst err",  32'(err_o),       32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("post rst ack c%0d", k), 32'(cbus_ack_o),    32'd0);
      check($sformatf("post rst snv c%0d", k), 32'(snoop_valid_o), 32'd0);
      step();
    end

    // Write request that never sees mbus ack: err rises, command stays up.
    req_valid_i = 1'b1;
    req_wr_i    = 1'b1;
    req_addr_i  = 32'h5000;
    step();
    req_valid_i = 1'b0;
    check("tmo mcmd start", 32'(mbus_cmd_o), 32'd3);
    repeat (250) @(posedge clk);
    #1;
    check("tmo err early", 32'(err_o),      32'd0);
    check("tmo mcmd mid",  32'(mbus_cmd_o), 32'd3);
    repeat (10) @(posedge clk);
    #1;
    check("tmo err late",  32'(err_o),       32'd1);
    check("tmo mcmd late", 32'(mbus_cmd_o),  32'd3);
    check("tmo maddr",     mbus_addr_o,      32'h5000);
    mbus_ack_i = 1'b1;
    step();
    mbus_ack_i = 1'b0;
    check("tmo mcmd after ack", 32'(mbus_cmd_o), 32'd0);
    cbus_cmd_i = 3'd3;
    step();
    check("tmo done", 32'(done_o),    32'd1);
    check("tmo dwr",  32'(done_wr_o), 32'd1);
    check("tmo ack",  32'(cbus_ack_o), 32'd1);
    cbus_cmd_i = 3'd0;
    step();

    // Enable with no request outstanding: acked, flagged, request side idle.
    do_reset();
    cbus_cmd_i = 3'd3;
    step();
    check("stray en ack",  32'(cbus_ack_o),  32'd1);
    check("stray en done", 32'(done_o),      32'd0);
    check("stray en err",  32'(err_o),       32'd1);
    check("stray en rdy",  32'(req_ready_o), 32'd1);
    cbus_cmd_i = 3'd0;
    step();
    check("stray en ack clr", 32'(cbus_ack_o), 32'd0);

    // Reserved cbus code: flagged, never acked; responder still usable after.
    do_reset();
    cbus_cmd_i = 3'd6;
    step();
    check("rsvd err", 32'(err_o),      32'd1);
    check("rsvd ack", 32'(cbus_ack_o), 32'd0);
    step();
    check("rsvd ack hold", 32'(cbus_ack_o), 32'd0);
    cbus_cmd_i  = 3'd2;
    cbus_addr_i = 32'h6000;
    step();
    check("rsvd then snoop snv",   32'(snoop_valid_o), 32'd1);
    check("rsvd then snoop saddr", snoop_addr_o,       32'h6000);
    check("rsvd then snoop swr",   32'(snoop_wr_o),    32'd0);
    cbus_cmd_i = 3'd0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
